// File: rtl/tea_engine.sv
// Iterative TEA cipher core: one Feistel cycle per clock, encrypt or decrypt
// chosen per block, valid/ready on both sides.

module tea_round #(
    parameter int             W = 32,
    parameter logic [W-1:0]   D = '0
) (
    input  logic              mode,
    input  logic [W-1:0]      v0,
    input  logic [W-1:0]      v1,
    input  logic [W-1:0]      sum,
    input  logic [3:0][W-1:0] k,
    output logic [W-1:0]      v0_n,
    output logic [W-1:0]      v1_n,
    output logic [W-1:0]      sum_n
);
    function automatic logic [W-1:0] f(input logic [W-1:0] x, s, ka, kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    logic [W-1:0] s_e, v0_e, v1_d;

    // Decrypt undoes the halves in reverse order using the pre-decrement sum.
    always_comb begin
        s_e  = sum + D;
        v0_e = v0 + f(v1, s_e, k[0], k[1]);
        v1_d = v1 - f(v0, sum, k[2], k[3]);
        if (!mode) begin
            v0_n  = v0_e;
            v1_n  = v1 + f(v0_e, s_e, k[2], k[3]);
            sum_n = s_e;
        end else begin
            v1_n  = v1_d;
            v0_n  = v0 - f(v1_d, sum, k[0], k[1]);
            sum_n = sum - D;
        end
    end
endmodule

module tea_engine #(
    parameter int          WORD_SIZE    = 32,
    parameter logic [31:0] DELTA        = 32'h9e3779b9,
    parameter int          ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic                 iMode,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oBusy
);
    localparam int                   CW   = $clog2(ROUND_NUMBER + 1);
    localparam logic [WORD_SIZE-1:0] D    = WORD_SIZE'(DELTA);
    // Decrypt starts from the sum the encrypt schedule ends on.
    localparam logic [WORD_SIZE-1:0] SD   = WORD_SIZE'(D * WORD_SIZE'(ROUND_NUMBER));
    localparam logic [CW-1:0]        LAST = CW'(ROUND_NUMBER - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state, state_n;
    logic   [WORD_SIZE-1:0]      v0, v1, sum;
    logic   [3:0][WORD_SIZE-1:0] key;
    logic                        mode;
    logic   [CW-1:0]             cnt;
    logic   [WORD_SIZE-1:0]      v0_n, v1_n, sum_n;

    tea_round #(.W(WORD_SIZE), .D(D)) u_round (
        .mode  (mode),
        .v0    (v0),
        .v1    (v1),
        .sum   (sum),
        .k     (key),
        .v0_n  (v0_n),
        .v1_n  (v1_n),
        .sum_n (sum_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (iValid)      state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    if (iReady)      state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0   <= '0;
            v1   <= '0;
            sum  <= '0;
            key  <= '0;
            mode <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (iValid) begin
                    v0   <= iV0;
                    v1   <= iV1;
                    key  <= {iK3, iK2, iK1, iK0};
                    mode <= iMode;
                    sum  <= iMode ? SD : '0;
                    cnt  <= '0;
                end
                RUN: begin
                    v0  <= v0_n;
                    v1  <= v1_n;
                    sum <= sum_n;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign oReady = (state == IDLE);
    assign oValid = (state == DONE);
    assign oBusy  = (state == RUN);
    assign oC0    = v0;
    assign oC1    = v1;
endmodule

// File: doc/tea_engine.md
# tea_engine

Unified iterative TEA block cipher core replacing the separate cipher/decipher pair under the TEA top level. One datapath performs encryption or decryption selected per block, at one Feistel cycle per clock. Word width, round count and delta are parametrised. Input and output use valid/ready handshakes, so the block can sit behind a FIFO or bus adapter with back-pressure.

## Interface
- WORD_SIZE, 32: width of each half-block and key word; all arithmetic is mod 2^WORD_SIZE.
- DELTA, 32'h9e3779b9: key-schedule constant; the low WORD_SIZE bits are used.
- ROUND_NUMBER, 32: TEA cycles per block; must be ≥1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- iValid  in  1  request valid.
- oReady  out  1  core can accept a request; high only in IDLE.
- iMode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- iV0, iV1  in  WORD_SIZE  input block halves; sampled at accept.
- iK0..iK3  in  WORD_SIZE each  key words; sampled at accept.
- oValid  out  1  result valid; high only in DONE.
- iReady  in  1  downstream accepts the result.
- oC0, oC1  out  WORD_SIZE  result halves; meaningful only while oValid=1.
- oBusy  out  1  high in RUN.

## Operation
- State registers: state, v0, v1, k0..k3, sum, mode, and round counter cnt of width $clog2(ROUND_NUMBER+1).
- Let D = DELTA[WORD_SIZE-1:0] and SD = (D*ROUND_NUMBER) mod 2^WORD_SIZE, an elaboration-time constant.
- F(x, s, ka, kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb). Shifts are logical. Bits shifted out are dropped.
- IDLE: oReady=1. On iValid=1, the edge loads v0/v1, keys and mode, clears cnt, sets sum=0 for encrypt or SD for decrypt, and moves to RUN.
- RUN, encrypt, each edge:
  - s' = sum+D
  - v0' = v0+F(v1, s', k0, k1)
  - v1' = v1+F(v0', s', k2, k3)
  - sum = s'
- RUN, decrypt, each edge:
  - v1' = v1−F(v0, sum, k2, k3)
  - v0' = v0−F(v1', sum, k0, k1)
  - sum = sum−D
- RUN: cnt increments each edge. The edge where cnt reaches ROUND_NUMBER−1 performs the last round and moves to DONE.
- DONE: oValid=1. oC0=v0 and oC1=v1, held stable. On iReady=1, the edge moves to IDLE.
- oC0/oC1 are driven from v0/v1 in all states. They change during RUN. After the handshake they keep the last result until the next accept.
- iValid outside IDLE is ignored. There is no request queue; the upstream holds the request until oReady.
- iMode and the key/data inputs may change freely after the accept edge.

## Timing
- Reset (asynchronous, immediate on rst=0):
  - state=IDLE
  - v0, v1, keys, sum, cnt = 0
  - oValid=0, oBusy=0, oC0=oC1=0
  - oReady=1 while rst=0 and after release
- Reset mid-RUN or mid-DONE aborts the block. No partial result is ever flagged valid.
- Latency: accept edge at t0. Rounds occur on edges t1..tN, where N=ROUND_NUMBER. oValid is high from just after tN.
- Minimum period with iReady held high and iValid held high: N+2 cycles.
  - t0: accept
  - tN: enter DONE
  - tN+1: return to IDLE
  - tN+2: next accept
- Back-pressure: with iReady=0, DONE persists indefinitely with outputs frozen and oReady=0.
- iValid and iReady are both high in DONE: only the output handshake completes. The new request is accepted on the following IDLE edge.
- ROUND_NUMBER=1: a single RUN cycle, so oValid rises after edge t1.

## Test plan
- Encrypt, WORD_SIZE=32, ROUND_NUMBER=32, key = 0, iV0=iV1=0 -> oC0=32'h41ea3a0a, oC1=32'h94baa940. oValid rises exactly 32 edges after accept; oBusy is high for those 32 cycles.
- Decrypt with the same config and key, iV0=32'h41ea3a0a, iV1=32'h94baa940 -> oC0=oC1=0 after 32 rounds.
- Back-pressure: hold iReady=0 for 5 cycles in DONE -> oValid, oC0 and oC1 stable, oReady=0. Pulse iValid during RUN with different data -> ignored; the result is unchanged.
- Assert rst=0 asynchronously at round 10 -> oValid=0, oBusy=0 and outputs 0 immediately, oReady=1. After release, a fresh encryption of the first vector still gives 41ea3a0a/94baa940.
- Legacy config, WORD_SIZE=16, ROUND_NUMBER=64, D=16'h79b9: 100 random blocks and keys -> results match the bit-exact reference model. Encrypting and then decrypting each block returns the original iV0/iV1.
- Streaming: iValid and iReady held high for 5 blocks -> accepts every N+2 cycles, each oValid lasts 1 cycle, and the results match the reference model in order.
